shift_tap_line: RTL and testbench

// - One row stage of the streaming pixel-window datapath: an 8-word shift register with two

---
 rtl/shift_tap_line.sv | 86 ++++++++
 tb/tb_shift_tap_line.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/shift_tap_line.sv
`default_nettype none
// ============================================================================
// Module   : shift_tap_line
// Purpose  : One row stage of a streaming pixel-window datapath. An
//            SHIFT_DEPTH-word shift register exposes its two newest words as
//            taps. Its oldest word is written into an addressed line-delay
//            memory. The memory's previous contents at the same address are
//            read out, so a word re-emerges one full line later.
// Ports    : clk        rising-edge clock
//            rst_n      synchronous active-low reset (stages + line_out only)
//            write_en   advance enable; when low all state holds
//            addr       line-memory location used by this advance
//            data_in    word shifted into stage 0
//            word_1     stage 0 (newest word)
//            word_2     stage 1 (previous word)
//            shift_out  stage SHIFT_DEPTH-1 (oldest word)
//            line_out   registered line-memory read data
// Revision : 1.0 - initial release
// ============================================================================
module shift_tap_line #(
  parameter int DATA_W      = 32,
  parameter int SHIFT_DEPTH = 8,
  parameter int ADDR_W      = 7,
  parameter int MEM_DEPTH   = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] word_1,
  output logic [DATA_W-1:0] word_2,
  output logic [DATA_W-1:0] shift_out,
  output logic [DATA_W-1:0] line_out
);

  logic [DATA_W-1:0] stage_q [SHIFT_DEPTH];
  logic [DATA_W-1:0] stage_d [SHIFT_DEPTH];
  logic [DATA_W-1:0] line_q;
  logic [DATA_W-1:0] line_d;
  logic [DATA_W-1:0] mem_q   [MEM_DEPTH];
  logic [DATA_W-1:0] mem_rd_w;

  // Old contents at addr; the write below lands on the same edge, so this
  // gives read-before-write behaviour.
  always_comb mem_rd_w = mem_q[addr];

  always_comb begin
    stage_d = stage_q;
    line_d  = line_q;
    if (write_en) begin
      stage_d[0] = data_in;
      for (int i = 1; i < SHIFT_DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
      line_d = mem_rd_w;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SHIFT_DEPTH; i++) begin
        stage_q[i] <= '0;
      end
      line_q <= '0;
    end else begin
      stage_q <= stage_d;
      line_q  <= line_d;
    end
  end

  // The line memory is never cleared; after a reset it still holds stale
  // words until the driver has completed one full address pass.
  always_ff @(posedge clk) begin
    if (rst_n && write_en) begin
      mem_q[addr] <= stage_q[SHIFT_DEPTH-1];
    end
  end

  assign word_1    = stage_q[0];
  assign word_2    = stage_q[1];
  assign shift_out = stage_q[SHIFT_DEPTH-1];
  assign line_out  = line_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_tap_line.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_tap_line
// Purpose  : Self-checking bench for shift_tap_line. Three instances are
//            chained line_out -> data_in. A history/array reference model
//            predicts every output of all three stages.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_tap_line;

  typedef struct packed {
    logic        v;   // expected value is known
    logic [31:0] d;
  } w_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        write_en;
  logic [6:0]  addr;
  logic [31:0] data_in;
  logic [31:0] w1 [3];
  logic [31:0] w2 [3];
  logic [31:0] so [3];
  logic [31:0] lo [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  shift_tap_line u0 (.clk(clk), .rst_n(rst_n), .write_en(write_en), .addr(addr),
                     .data_in(data_in), .word_1(w1[0]), .word_2(w2[0]),
                     .shift_out(so[0]), .line_out(lo[0]));
  shift_tap_line u1 (.clk(clk), .rst_n(rst_n), .write_en(write_en), .addr(addr),
                     .data_in(lo[0]), .word_1(w1[1]), .word_2(w2[1]),
                     .shift_out(so[1]), .line_out(lo[1]));
  shift_tap_line u2 (.clk(clk), .rst_n(rst_n), .write_en(write_en), .addr(addr),
                     .data_in(lo[1]), .word_1(w1[2]), .word_2(w2[2]),
                     .shift_out(so[2]), .line_out(lo[2]));

  // Reference model: per stage, the list of words accepted since reset,
  // a line memory of (known, value) pairs, and the expected line_out.
  w_t hist   [3][$];
  w_t mem_m  [3][128];
  w_t line_m [3];

  function automatic w_t known(input logic [31:0] d);
    w_t r;
    r.v = 1'b1;
    r.d = d;
    return r;
  endfunction

  // Word accepted 'back' advances before the newest; zero if none since reset.
  function automatic w_t hist_at(input int i, input int back);
    if (hist[i].size() > back) return hist[i][hist[i].size() - 1 - back];
    return known(32'h0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      hist[i].delete();
      line_m[i] = known(32'h0);
    end
  endtask

  task automatic model_adv(input logic [6:0] a, input logic [31:0] d);
    w_t in_w [3];
    w_t oldest;
    in_w[0] = known(d);
    in_w[1] = line_m[0];
    in_w[2] = line_m[1];
    for (int i = 0; i < 3; i++) begin
      oldest       = hist_at(i, 7);
      line_m[i]    = mem_m[i][a];
      mem_m[i][a]  = oldest;
      hist[i].push_back(in_w[i]);
      if (hist[i].size() > 16) void'(hist[i].pop_front());
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input w_t exp);
    if (exp.v) begin
      checks++;
      assert (obs === exp.d)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp.d);
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d.word_1", i),    w1[i], hist_at(i, 0));
      chk($sformatf("u%0d.word_2", i),    w2[i], hist_at(i, 1));
      chk($sformatf("u%0d.shift_out", i), so[i], hist_at(i, 7));
      chk($sformatf("u%0d.line_out", i),  lo[i], line_m[i]);
    end
  endtask

  task automatic do_reset(input int cycles);
    rst_n    = 1'b0;
    write_en = 1'b1;
    data_in  = 32'hFFFF_FFFF;
    repeat (cycles) @(posedge clk);
    model_reset();
    #1;
    check_all();
    rst_n = 1'b1;
  endtask

  task automatic adv(input logic we, input logic [6:0] a, input logic [31:0] d);
    write_en = we;
    addr     = a;
    data_in  = d;
    @(posedge clk);
    if (we) model_adv(a, d);
    #1;
    check_all();
  endtask

  initial begin
    int   acnt;
    logic we;
    w_t   a_word;

    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 128; j++) begin
        mem_m[i][j].v = 1'b0;
        mem_m[i][j].d = 32'h0;
      end
    end
    rst_n    = 1'b0;
    write_en = 1'b0;
    addr     = '0;
    data_in  = '0;

    // Reset with write_en high and all-ones data must still clear outputs.
    do_reset(2);

    // Ramp with addr cycling 0..75, plus a 5-clock hold before advance 50.
    for (int n = 1; n <= 260; n++) begin
      if (n == 50) begin
        for (int k = 0; k < 5; k++) adv(1'b0, 7'($urandom_range(0, 127)), $urandom);
      end
      adv(1'b1, 7'((n - 1) % 76), 32'(n));
      if (n == 10) begin
        chk("ramp10.word_1", w1[0], known(32'd10));
        chk("ramp10.word_2", w2[0], known(32'd9));
        chk("ramp10.shift_out", so[0], known(32'd3));
      end
      if (n == 80)  chk("line80.zero", lo[0], known(32'd0));
      if (n == 100) chk("line100", lo[0], known(32'd16));
    end
    acnt = 260;

    // Random data with random advance gaps, driver-style addressing.
    for (int k = 0; k < 300; k++) begin
      we = ($urandom_range(0, 3) != 0);
      adv(we, 7'(acnt % 76), $urandom);
      if (we) acnt++;
    end

    // Mid-run reset: stages/line_out clear, memory keeps stale words.
    do_reset(1);
    acnt = 0;
    for (int k = 0; k < 200; k++) begin
      we = ($urandom_range(0, 4) != 0);
      adv(we, 7'(acnt % 76), $urandom);
      if (we) acnt++;
    end

    // Arbitrary addresses across the whole memory.
    for (int k = 0; k < 150; k++) begin
      adv(($urandom_range(0, 3) != 0), 7'($urandom_range(0, 127)), $urandom);
    end

    // Same-address read-before-write: the word stored at addr 5 on one
    // advance must come back on the next advance at addr 5.
    a_word = hist_at(0, 7);
    adv(1'b1, 7'd5, $urandom);
    for (int k = 6; k < 12; k++) adv(1'b1, 7'(k), $urandom);
    adv(1'b1, 7'd5, $urandom);
    chk("same_addr", lo[0], a_word);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
